// File: rtl/mult_pkg.sv
// Shared constants and enumerations for the radix-4 Booth sequential multiplier.
package mult_pkg;

  localparam int WIDTH_C = 32;
  localparam int EXT_C   = 34;
  localparam int ITER_C  = 16;

  // Controller states of the multiply unit
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_e;

  // Partial-product selection produced by the Booth recoder
  typedef enum logic [2:0] {
    B_ZERO,
    B_POS1,
    B_POS2,
    B_NEG1,
    B_NEG2
  } booth_sel_e;

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth recoder: maps the 3-bit multiplier window {b[i+1], b[i], b[i-1]}
// onto one of the five multiples of the multiplicand.
module booth_enc
  import mult_pkg::*;
(
  input  logic [2:0] window,
  output booth_sel_e sel
);

  // Pure decode of the overlapping window; 000 and 111 contribute nothing
  always_comb begin
    sel = B_ZERO;
    case (window)
      3'b001, 3'b010: sel = B_POS1;
      3'b011:         sel = B_POS2;
      3'b100:         sel = B_NEG2;
      3'b101, 3'b110: sel = B_NEG1;
      default:        sel = B_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier, radix-4 Booth, two multiplier bits retired per
// cycle. Returns the low WIDTH product bits, an overflow flag and a ready pulse.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_C,
  parameter int ITER  = WIDTH / 2
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // Two guard bits let the high half hold +-2 * (most negative operand) without wrapping
  localparam int EXT = WIDTH + 2;
  localparam int CW  = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  mult_state_e state;
  logic [CW-1:0]    count;
  logic [EXT-1:0]   m;
  logic [EXT-1:0]   m2;
  logic [EXT-1:0]   h;
  logic [WIDTH-1:0] l;
  logic             q;

  booth_sel_e       sel;
  logic [EXT-1:0]   addend;
  logic             cin;
  logic [EXT-1:0]   h_sum;
  logic [EXT-1:0]   h_shift;
  logic [WIDTH-1:0] l_shift;
  logic             q_shift;
  logic [EXT:0]     sign_run;
  logic             overflow;

  booth_enc u_enc (
    .window ({l[1], l[0], q}),
    .sel    (sel)
  );

  // Selected multiple is added into the high half; subtraction is invert plus carry-in
  always_comb begin
    addend = '0;
    cin    = 1'b0;
    case (sel)
      B_POS1: addend = m;
      B_POS2: addend = m2;
      B_NEG1: begin
        addend = ~m;
        cin    = 1'b1;
      end
      B_NEG2: begin
        addend = ~m2;
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
    h_sum = h + addend + EXT'(cin);
  end

  // Arithmetic right shift by two of {h_sum, l, q}; the product is a pure sign
  // extension into the top bits only when all of H and L's MSB agree
  always_comb begin
    h_shift  = {{2{h_sum[EXT-1]}}, h_sum[EXT-1:2]};
    l_shift  = {h_sum[1:0], l[WIDTH-1:2]};
    q_shift  = l[1];
    sign_run = {h_shift, l_shift[WIDTH-1]};
    overflow = !((&sign_run) || !(|sign_run));
  end

  // Controller and datapath registers; a start is honoured in every state and a
  // start on the completion edge still lets the finishing operation report
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      m              <= '0;
      m2             <= '0;
      h              <= '0;
      l              <= '0;
      q              <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;

      case (state)
        RUN: begin
          h     <= h_shift;
          l     <= l_shift;
          q     <= q_shift;
          count <= count + 1'b1;
          if (count == LAST) begin
            data_result    <= l_shift;
            data_exception <= overflow;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (ctrl_MULT) begin
        m     <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
        m2    <= {data_operandA[WIDTH-1], data_operandA, 1'b0};
        h     <= '0;
        l     <= data_operandB;
        q     <= 1'b0;
        count <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end
    end
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Sequential signed 32×32 multiplier using radix-4 Booth recoding, the multi-cycle multiply unit of the processor execute stage. It takes a one-cycle start pulse with two operands and forms {+A, +2A, −A, −2A} from a 34-bit sign-extended multiplicand. It retires 2 multiplier bits per cycle and returns the low 32 bits of the product, an overflow flag and a one-cycle ready pulse.

## Interface
- WIDTH, 32, operand/result width; must be even
- ITER, WIDTH/2 (16), Booth iterations per multiply

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- ctrl_MULT  in  1  start pulse; operands sampled on the same edge
- data_operandA  in  WIDTH  multiplicand, two's complement
- data_operandB  in  WIDTH  multiplier, two's complement
- data_result  out  WIDTH  low WIDTH bits of product; held until next completion
- data_exception  out  1  product not representable in signed WIDTH bits; held with data_result
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  high while iterating

## Operation
- States: IDLE, RUN, DONE. All three states return to IDLE on reset.
- Start sample: ctrl_MULT sampled high in any state causes the following at that edge:
  - Latch M = sext34(A) and M2 = M shifted left by one bit (bit 0 = 0).
  - Load P = {34'b0, B, 1'b0} (67 bits: H[33:0], L[31:0], q).
  - Set count = 0 and go to RUN.
- ctrl_MULT during RUN aborts the current operation and restarts with the new operands. No RDY pulse is produced for the aborted operation.
- RUN step, per edge:
  - Booth-encode {L[1], L[0], q}:
    - 000/111 → 0
    - 001/010 → +M
    - 011 → +M2
    - 100 → −M2
    - 101/110 → −M
  - H' = H + sel, computed modulo 2^34. Negation is two's complement (invert + carry-in).
  - P ← arithmetic right shift by 2 of {H', L, q}. Sign fills from H'[33].
  - count++.
- On the ITER-th step edge:
  - Full product = {H[31:0], L} after the shift.
  - data_result ← L.
  - data_exception ← 1 unless H[33:0] and L[31] are all equal. This means the upper 33 bits of the 64-bit product must be a pure sign extension.
  - data_resultRDY ← 1; state → DONE.
- DONE lasts one cycle. It goes to IDLE, or to RUN if ctrl_MULT is high.
- Width rules:
  - 34-bit H absorbs ±2·(−2^31) without wrap.
  - The 64-bit product is exact for all inputs, including −2^31 × −2^31.

## Timing
- Reset values:
  - data_result = 0
  - data_exception = 0
  - data_resultRDY = 0
  - busy = 0
  - state = IDLE
  - count = 0
- Start sampled at edge k → iterations at edges k+1 … k+16.
- data_result, data_exception and data_resultRDY are registered at edge k+16. data_resultRDY is high only during the cycle after edge k+16: latency 16 cycles, one pulse.
- busy is high in cycles following edges k … k+15 and low from edge k+16.
- Back-to-back: ctrl_MULT at edge k+16 (the completion edge) is accepted. RDY still pulses for the first operation, and the second completes at k+32.
- Operand inputs are don't-care except on the sampling edge.
- Reset mid-RUN: the next edge returns the block to IDLE with no RDY pulse. Previously held outputs are cleared to 0.
- Reset and ctrl_MULT on the same edge: reset wins, and the start is dropped.

## Structure
- Package mult_pkg:
  - WIDTH_C = 32, EXT_C = 34, ITER_C = 16
  - state enum {IDLE, RUN, DONE}
  - Booth select enum {B_ZERO, B_POS1, B_POS2, B_NEG1, B_NEG2}
- Sub-module booth_enc: combinational, 3-bit window in → Booth select out.
- The adder, the shift and the 5-bit counter stay in the top module.

## Test plan
- 3 × 5 → after 16 cycles: data_result = 15, exception = 0, RDY high exactly one cycle.
- −7 × 6, then −1 × −1 back-to-back:
  - first: data_result = 0xFFFFFFD6 (−42), exception = 0
  - second: data_result = 1, exception = 0, completing 16 cycles later
- 0x7FFFFFFF × 2 → data_result = 0xFFFFFFFE, exception = 1. 0x80000000 × 0xFFFFFFFF → data_result = 0x80000000, exception = 1.
- 0x80000000 × 0x80000000 → data_result = 0, exception = 1. 0x80000000 × 1 → data_result = 0x80000000, exception = 0.
- Start 12 × 12, re-pulse ctrl_MULT at cycle 5 with 2 × 3 → a single RDY 16 cycles after the second pulse, data_result = 6.
- Start 9 × 9, assert reset at cycle 8 → no RDY ever, all outputs 0. A start after reset → normal 81.
